axis_tx_pattern_gen: RTL and testbench

- Parametrised AXI4-Stream test-frame generator for the Ethernet control path.
- Emits a configurable number of frames of runtime-selectable byte length, payload pattern and inter-frame gap.
- Uses a fully compliant valid/ready handshake: tvalid is never gated by tready.
- Drives the MAC TX stream during bring-up and loopback tests, and reports progress to control logic.

---
 rtl/axis_tx_pattern_gen.sv | 217 +++++++++++++++++++++
 tb/tb_axis_tx_pattern_gen.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_tx_pattern_gen.sv
// AXI4-Stream test-frame generator: counted or continuous runs of fixed-length
// frames with a selectable payload pattern and inter-frame gap.
module axis_tx_pattern_gen #(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 32,
  parameter int GAP_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic                    stop,
  input  logic [1:0]              mode,
  input  logic [7:0]              fill_byte,
  input  logic [LEN_WIDTH-1:0]    frame_len,
  input  logic [CNT_WIDTH-1:0]    frame_num,
  input  logic [GAP_WIDTH-1:0]    ifg,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_WIDTH-1:0]    frames_sent,
  output logic [LEN_WIDTH-1:0]    tx_size,
  output logic [DATA_WIDTH-1:0]   tx_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] tx_axis_tkeep,
  output logic                    tx_axis_tvalid,
  output logic                    tx_axis_tlast,
  input  logic                    tx_axis_tready
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int NREP  = DATA_WIDTH / 32;
  localparam int KW    = LEN_WIDTH + 1;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [BYTES-1:0]      keep;
    logic                  last;
  } beat_t;

  // Right-shifting Galois form of x^32+x^22+x^2+x+1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  function automatic beat_t build_beat(input logic [LEN_WIDTH-1:0] beat,
                                       input logic [31:0]          word,
                                       input logic [31:0]          lfsr,
                                       input logic [1:0]           md,
                                       input logic [7:0]           fill,
                                       input logic [LEN_WIDTH-1:0] len);
    beat_t                b;
    logic [LEN_WIDTH-1:0] last_idx;
    logic [BSH-1:0]       rem;
    logic [KW-1:0]        k;
    last_idx = (len - LEN_WIDTH'(1)) >> BSH;
    rem      = len[BSH-1:0];
    b.last   = (beat == last_idx);
    b.data   = '0;
    b.keep   = '0;
    for (int j = 0; j < BYTES; j++) begin
      k = ({1'b0, beat} << BSH) + KW'(j);
      b.keep[j] = !b.last || (rem == '0) || (BSH'(j) < rem);
      case (md)
        2'd1:    b.data[8*j +: 8] = (k < {1'b0, len}) ? k[7:0] : 8'h00;
        2'd3:    b.data[8*j +: 8] = fill;
        default: ;
      endcase
    end
    if (md == 2'd0)      b.data = DATA_WIDTH'(word);
    else if (md == 2'd2) b.data = {NREP{lfsr}};
    return b;
  endfunction

  state_t                r_state;
  logic [1:0]            r_mode;
  logic [7:0]            r_fill;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [CNT_WIDTH-1:0]  r_num;
  logic [GAP_WIDTH-1:0]  r_ifg;
  logic [GAP_WIDTH-1:0]  r_gap;
  logic                  r_stop_pend;
  logic [LEN_WIDTH-1:0]  r_beat;
  logic [31:0]           r_word;
  logic [31:0]           r_lfsr;
  logic                  r_busy;
  logic                  r_done;
  logic [CNT_WIDTH-1:0]  r_frames_sent;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic [BYTES-1:0]      r_tkeep;
  logic                  r_tvalid;
  logic                  r_tlast;

  logic                 w_hs;
  logic                 w_finish;
  logic [CNT_WIDTH-1:0] w_sent_nx;
  logic [LEN_WIDTH-1:0] w_beat_nx;
  logic [31:0]          w_word_nx;
  logic [31:0]          w_lfsr_nx;
  beat_t                w_first;
  beat_t                w_cont;
  beat_t                w_resume;

  assign w_hs      = r_tvalid & tx_axis_tready;
  assign w_sent_nx = r_frames_sent + CNT_WIDTH'(1);
  assign w_finish  = ((r_num != '0) && (w_sent_nx == r_num)) || r_stop_pend || stop;
  assign w_beat_nx = r_tlast ? '0 : r_beat + LEN_WIDTH'(1);
  assign w_word_nx = r_word + 32'd1;
  assign w_lfsr_nx = lfsr_step(r_lfsr);

  // First beat uses the live config inputs since they are latched on the same edge.
  assign w_first  = build_beat('0, 32'd0, r_lfsr, mode, fill_byte, frame_len);
  assign w_cont   = build_beat(w_beat_nx, w_word_nx, w_lfsr_nx, r_mode, r_fill, r_len);
  assign w_resume = build_beat('0, r_word, r_lfsr, r_mode, r_fill, r_len);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_mode        <= '0;
      r_fill        <= '0;
      r_len         <= '0;
      r_num         <= '0;
      r_ifg         <= '0;
      r_gap         <= '0;
      r_stop_pend   <= 1'b0;
      r_beat        <= '0;
      r_word        <= '0;
      r_lfsr        <= 32'h0000_0001;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_frames_sent <= '0;
      r_tdata       <= '0;
      r_tkeep       <= '0;
      r_tvalid      <= 1'b0;
      r_tlast       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (stop && (r_state != S_IDLE)) r_stop_pend <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (start && (frame_len != '0)) begin
            r_mode        <= mode;
            r_fill        <= fill_byte;
            r_len         <= frame_len;
            r_num         <= frame_num;
            r_ifg         <= ifg;
            r_frames_sent <= '0;
            r_busy        <= 1'b1;
            r_beat        <= '0;
            r_word        <= '0;
            r_tdata       <= w_first.data;
            r_tkeep       <= w_first.keep;
            r_tlast       <= w_first.last;
            r_tvalid      <= 1'b1;
            r_state       <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_hs) begin
            r_word <= w_word_nx;
            r_lfsr <= w_lfsr_nx;
            r_beat <= w_beat_nx;
            if (r_tlast) r_frames_sent <= w_sent_nx;
            if (r_tlast && (w_finish || (r_ifg != '0))) begin
              r_tvalid <= 1'b0;
              r_tkeep  <= '0;
              r_tdata  <= '0;
              r_tlast  <= 1'b0;
              if (w_finish) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_DONE;
              end else begin
                r_gap   <= r_ifg;
                r_state <= S_GAP;
              end
            end else begin
              r_tdata <= w_cont.data;
              r_tkeep <= w_cont.keep;
              r_tlast <= w_cont.last;
            end
          end
        end
        S_GAP: begin
          if (r_stop_pend || stop) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else if (r_gap == GAP_WIDTH'(1)) begin
            r_tdata  <= w_resume.data;
            r_tkeep  <= w_resume.keep;
            r_tlast  <= w_resume.last;
            r_tvalid <= 1'b1;
            r_state  <= S_SEND;
          end else begin
            r_gap <= r_gap - GAP_WIDTH'(1);
          end
        end
        S_DONE: begin
          r_stop_pend <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign frames_sent    = r_frames_sent;
  assign tx_size        = r_len;
  assign tx_axis_tdata  = r_tdata;
  assign tx_axis_tkeep  = r_tkeep;
  assign tx_axis_tvalid = r_tvalid;
  assign tx_axis_tlast  = r_tlast;
endmodule

// File: tb/tb_axis_tx_pattern_gen.sv
// Testbench for axis_tx_pattern_gen: vector table of runs checked against a
// byte-level frame model, plus stop, ignored-start and mid-frame reset sequences.
module tb_axis_tx_pattern_gen;
  localparam int DW = 64;
  localparam int LW = 16;
  localparam int CW = 32;
  localparam int GW = 8;
  localparam int NB = DW / 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [1:0]    mode = '0;
  logic [7:0]    fill_byte = '0;
  logic [LW-1:0] frame_len = '0;
  logic [CW-1:0] frame_num = '0;
  logic [GW-1:0] ifg = '0;
  logic          busy, done;
  logic [CW-1:0] frames_sent;
  logic [LW-1:0] tx_size;
  logic [DW-1:0] tx_axis_tdata;
  logic [NB-1:0] tx_axis_tkeep;
  logic          tx_axis_tvalid, tx_axis_tlast;
  logic          tx_axis_tready = 1'b1;

  axis_tx_pattern_gen #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .CNT_WIDTH(CW), .GAP_WIDTH(GW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .mode(mode),
    .fill_byte(fill_byte), .frame_len(frame_len), .frame_num(frame_num), .ifg(ifg),
    .busy(busy), .done(done), .frames_sent(frames_sent), .tx_size(tx_size),
    .tx_axis_tdata(tx_axis_tdata), .tx_axis_tkeep(tx_axis_tkeep),
    .tx_axis_tvalid(tx_axis_tvalid), .tx_axis_tlast(tx_axis_tlast),
    .tx_axis_tready(tx_axis_tready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [NB-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct {
    logic [1:0] md;
    int         len;
    int         num;
    int         gap;
    logic [7:0] fl;
    bit         rnd;
    int         beats;
    logic [7:0] lkeep;
    logic [63:0] ldata;
    bit         chk_ldata;
  } vec_t;

  beat_t       cap[$];
  beat_t       expq[$];
  int          gaps[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_lfsr = 32'h1;
  bit          rnd_ready = 1'b0;
  bit          mon_en = 1'b0;
  int          cyc = 0, last_cyc = -10, done_cyc = -20;
  bit          in_gap = 1'b0;
  int          gap_cnt = 0;
  bit          prev_stall = 1'b0, prev_mid = 1'b0;
  beat_t       prev_b;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] poly;
    poly = (32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1;
    return s[0] ? ((s >> 1) ^ poly) : (s >> 1);
  endfunction

  // Byte-level model of a whole run: appends every beat the sink should see.
  task automatic gen_expect(input logic [1:0] md, input int len, input int nfr, input logic [7:0] fl);
    logic [63:0] word;
    int          nbeats;
    int          idx;
    beat_t       e;
    word   = 64'd0;
    nbeats = (len + NB - 1) / NB;
    for (int f = 0; f < nfr; f++) begin
      for (int b = 0; b < nbeats; b++) begin
        e = '0;
        for (int j = 0; j < NB; j++) begin
          idx = b * NB + j;
          e.keep[j] = (idx < len);
          if (md == 2'd1) e.data[8*j +: 8] = (idx < len) ? idx[7:0] : 8'h00;
          if (md == 2'd3) e.data[8*j +: 8] = fl;
        end
        if (md == 2'd0) e.data = word;
        if (md == 2'd2) e.data = {m_lfsr, m_lfsr};
        e.last = (b == nbeats - 1);
        expq.push_back(e);
        word   = word + 64'd1;
        m_lfsr = lfsr_next(m_lfsr);
      end
    end
  endtask

  initial forever begin
    @(posedge clk); #1;
    tx_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    beat_t b;
    b = {tx_axis_tdata, tx_axis_tkeep, tx_axis_tlast};
    cyc++;
    if (!mon_en) begin
      prev_stall = 1'b0;
      prev_mid   = 1'b0;
      in_gap     = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", 128'({tx_axis_tvalid, b}), 128'({1'b1, prev_b}));
      if (prev_mid) chk("no_mid_drop", 128'(tx_axis_tvalid), 128'(1'b1));
      if (!tx_axis_tvalid && (tx_axis_tkeep != '0)) chk("idle_keep", 128'(tx_axis_tkeep), 128'(0));
      if (done) done_cyc = cyc;
      if (in_gap && !tx_axis_tvalid) gap_cnt++;
      if (in_gap && tx_axis_tvalid) begin
        gaps.push_back(gap_cnt);
        in_gap = 1'b0;
      end
      prev_stall = tx_axis_tvalid && !tx_axis_tready;
      prev_b     = b;
      prev_mid   = tx_axis_tvalid && tx_axis_tready && !tx_axis_tlast;
      if (tx_axis_tvalid && tx_axis_tready) begin
        cap.push_back(b);
        if (tx_axis_tlast) begin
          last_cyc = cyc;
          in_gap   = 1'b1;
          gap_cnt  = 0;
        end
      end
    end
  end

  task automatic start_pulse(input logic [1:0] md, input int len, input int num, input int gap, input logic [7:0] fl);
    @(posedge clk); #1;
    mode = md; frame_len = LW'(len); frame_num = CW'(num); ifg = GW'(gap); fill_byte = fl;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string p);
    int n;
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    chk({p, "_done_seen"}, 128'(done), 128'(1'b1));
  endtask

  task automatic cmp_beats(input string p, input int n);
    chk({p, "_beat_count"}, 128'(cap.size()), 128'(n));
    for (int i = 0; i < cap.size() && i < expq.size(); i++)
      chk($sformatf("%s_beat%0d", p, i), 128'(cap[i]), 128'(expq[i]));
  endtask

  task automatic run_vec(input vec_t v, input int id);
    string p;
    p = $sformatf("v%0d", id);
    expq.delete(); cap.delete(); gaps.delete(); in_gap = 1'b0;
    gen_expect(v.md, v.len, v.num, v.fl);
    rnd_ready = v.rnd;
    start_pulse(v.md, v.len, v.num, v.gap, v.fl);
    chk({p, "_first_valid"}, 128'(tx_axis_tvalid), 128'(1'b1));
    chk({p, "_busy"}, 128'(busy), 128'(1'b1));
    chk({p, "_tx_size"}, 128'(tx_size), 128'(v.len));
    wait_done(p);
    chk({p, "_frames_sent"}, 128'(frames_sent), 128'(v.num));
    chk({p, "_busy_low"}, 128'(busy), 128'(1'b0));
    @(negedge clk); #1;
    chk({p, "_done_pulse"}, 128'(done), 128'(1'b0));
    chk({p, "_done_lat"}, 128'(done_cyc), 128'(last_cyc + 1));
    rnd_ready = 1'b0;
    cmp_beats(p, v.beats);
    if (cap.size() > 0) begin
      chk({p, "_last_keep"}, 128'(cap[cap.size()-1].keep), 128'(v.lkeep));
      if (v.chk_ldata) chk({p, "_last_data"}, 128'(cap[cap.size()-1].data), 128'(v.ldata));
    end
    chk({p, "_gap_count"}, 128'(gaps.size()), 128'(v.num - 1));
    foreach (gaps[i]) chk($sformatf("%s_gap%0d", p, i), 128'(gaps[i]), 128'(v.gap));
  endtask

  vec_t vt[5];
  vec_t vpost;

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", 128'(tx_axis_tvalid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_frames", 128'(frames_sent), 128'(0));
    chk("rst_size", 128'(tx_size), 128'(0));
    chk("rst_data", 128'({tx_axis_tdata, tx_axis_tkeep, tx_axis_tlast}), 128'(0));
    rstn = 1'b1;
    mon_en = 1'b1;

    vt[0] = '{2'd2, 100, 2, 1, 8'h00, 1'b1, 26, 8'h0F, 64'h0, 1'b0};
    vt[1] = '{2'd0, 64, 1, 0, 8'h00, 1'b0, 8, 8'hFF, 64'h7, 1'b1};
    vt[2] = '{2'd1, 61, 2, 3, 8'h00, 1'b0, 16, 8'h1F, 64'h0000_003C_3B3A_3938, 1'b1};
    vt[3] = '{2'd3, 9, 3, 1, 8'hA5, 1'b1, 6, 8'h01, {8{8'hA5}}, 1'b1};
    vt[4] = '{2'd0, 8, 2, 0, 8'h00, 1'b0, 2, 8'hFF, 64'h1, 1'b1};
    for (int i = 0; i < 5; i++) run_vec(vt[i], i);

    // Continuous run stopped during frame 5.
    expq.delete(); cap.delete(); gaps.delete();
    gen_expect(2'd0, 16, 5, 8'h00);
    start_pulse(2'd0, 16, 0, 0, 8'h00);
    n = 0;
    while (cap.size() < 9 && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    chk("stop_reach_f5", 128'(cap.size()), 128'(9));
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    wait_done("stop");
    chk("stop_frames", 128'(frames_sent), 128'(5));
    chk("stop_busy", 128'(busy), 128'(0));
    @(negedge clk); #1;
    cmp_beats("stop", 10);

    // Zero-length start and start while busy are both ignored.
    cap.delete();
    start_pulse(2'd1, 0, 3, 0, 8'h00);
    repeat (5) @(negedge clk);
    chk("len0_valid", 128'(tx_axis_tvalid), 128'(0));
    chk("len0_busy", 128'(busy), 128'(0));
    chk("len0_size", 128'(tx_size), 128'(16));
    chk("len0_beats", 128'(cap.size()), 128'(0));
    expq.delete(); cap.delete(); gaps.delete(); in_gap = 1'b0;
    gen_expect(2'd3, 24, 2, 8'h3C);
    start_pulse(2'd3, 24, 2, 2, 8'h3C);
    start_pulse(2'd0, 8, 5, 0, 8'h11);
    chk("busy_start_size", 128'(tx_size), 128'(24));
    wait_done("busy_start");
    chk("busy_start_frames", 128'(frames_sent), 128'(2));
    repeat (10) @(negedge clk);
    cmp_beats("busy_start", 6);
    chk("busy_start_gap", 128'(gaps.size() > 0 ? gaps[0] : -1), 128'(2));
    chk("no_extra_frame", 128'(tx_axis_tvalid), 128'(0));

    // Asynchronous reset in the middle of frame 2.
    cap.delete();
    start_pulse(2'd1, 40, 3, 0, 8'h00);
    n = 0;
    while (cap.size() < 7 && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    chk("rst_pre_frames", 128'(frames_sent), 128'(1));
    mon_en = 1'b0;
    #1 rstn = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(tx_axis_tvalid), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_frames", 128'(frames_sent), 128'(0));
    chk("mid_rst_keep", 128'(tx_axis_tkeep), 128'(0));
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    m_lfsr = 32'h1;
    @(negedge clk);
    mon_en = 1'b1;
    vpost = '{2'd2, 16, 1, 0, 8'h00, 1'b0, 2, 8'hFF, {2{32'h8020_0003}}, 1'b1};
    run_vec(vpost, 9);
    if (cap.size() > 0) chk("post_rst_lfsr0", 128'(cap[0].data), 128'({2{32'h0000_0001}}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
